mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 26 ++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the two-requester memory arbiter:
// FSM states, requester ids and the fetch/load-store region boundary.
package mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_LS    = 1'b1
    } req_id_t;

    // Fetch owns addresses below this, load/store owns it and above.
    localparam int REGION_BASE = 128;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin pick between fetch and load/store.
// Ports: i_f_req, i_ls_req, i_last_win in; o_valid, o_win out.
module rr_arb2
    import mem_pkg::*;
(
    input  logic    i_f_req,
    input  logic    i_ls_req,
    input  req_id_t i_last_win,
    output logic    o_valid,
    output req_id_t o_win
);

    always_comb begin
        o_valid = i_f_req | i_ls_req;
        o_win   = REQ_FETCH;
        unique case (1'b1)
            (i_f_req && i_ls_req):
                o_win = (i_last_win == REQ_LS) ? REQ_FETCH : REQ_LS;
            (i_ls_req && !i_f_req):
                o_win = REQ_LS;
            default:
                o_win = REQ_FETCH;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store onto one single-port memory, one
// transaction in flight. Ports: fetch req/gnt/rdata, ls req/gnt/rdata,
// err, registered mem_* command, mem_rdata, saturating conflict_cnt.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic [DW-1:0] f_rdata,
    output logic          f_rvalid,
    input  logic          ls_req,
    input  logic          ls_rd,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,
    output logic          err,
    output logic          mem_en,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [CW-1:0] conflict_cnt
);

    localparam logic [AW-1:0] REGION = AW'(REGION_BASE);

    state_t        r_state;
    state_t        w_state_nxt;
    req_id_t       r_last_win;
    req_id_t       w_win;
    logic          w_any;
    logic          w_grant;
    logic          w_conflict;
    logic          w_legal;
    logic          w_sel_rd;
    logic [AW-1:0] w_sel_addr;

    logic          r_f_gnt;
    logic          r_ls_gnt;
    logic          r_f_rvalid;
    logic          r_ls_rvalid;
    logic          r_err;
    logic          r_mem_en;
    logic          r_mem_rd;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_f_rdata;
    logic [DW-1:0] r_ls_rdata;
    logic [CW-1:0] r_cnt;

    rr_arb2 u_rr (
        .i_f_req    (f_req),
        .i_ls_req   (ls_req),
        .i_last_win (r_last_win),
        .o_valid    (w_any),
        .o_win      (w_win)
    );

    always_comb begin
        w_grant    = (r_state == S_IDLE) && w_any;
        w_conflict = (r_state == S_IDLE) && f_req && ls_req;
        w_sel_addr = f_addr;
        w_sel_rd   = 1'b1;
        w_legal    = (f_addr < REGION);
        if (w_win == REQ_LS) begin
            w_sel_addr = ls_addr;
            w_sel_rd   = ls_rd;
            w_legal    = (ls_addr >= REGION);
        end
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
            // Only a legal read leaves ISSUE for WAIT.
            S_ISSUE: w_state_nxt = (r_mem_en && r_mem_rd) ? S_WAIT : S_IDLE;
            S_WAIT:  w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_win  <= REQ_LS;
            r_f_gnt     <= 1'b0;
            r_ls_gnt    <= 1'b0;
            r_f_rvalid  <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_err       <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_rd    <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_f_rdata   <= '0;
            r_ls_rdata  <= '0;
            r_cnt       <= '0;
        end else begin
            r_f_gnt     <= w_grant && (w_win == REQ_FETCH);
            r_ls_gnt    <= w_grant && (w_win == REQ_LS);
            r_err       <= w_grant && !w_legal;
            r_mem_en    <= w_grant && w_legal;
            r_f_rvalid  <= (r_state == S_WAIT) && (r_last_win == REQ_FETCH);
            r_ls_rvalid <= (r_state == S_WAIT) && (r_last_win == REQ_LS);
            if (w_grant) begin
                r_last_win <= w_win;
                // Illegal grants leave the memory command untouched.
                if (w_legal) begin
                    r_mem_rd   <= w_sel_rd;
                    r_mem_addr <= w_sel_addr;
                    if (w_win == REQ_LS) r_mem_wdata <= ls_wdata;
                end
            end
            if (r_state == S_WAIT) begin
                if (r_last_win == REQ_FETCH) r_f_rdata  <= mem_rdata;
                else                         r_ls_rdata <= mem_rdata;
            end
            if (w_conflict && (r_cnt != '1)) r_cnt <= r_cnt + CW'(1);
        end
    end

    assign f_gnt        = r_f_gnt;
    assign ls_gnt       = r_ls_gnt;
    assign f_rvalid     = r_f_rvalid;
    assign ls_rvalid    = r_ls_rvalid;
    assign err          = r_err;
    assign mem_en       = r_mem_en;
    assign mem_rd       = r_mem_rd;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign f_rdata      = r_f_rdata;
    assign ls_rdata     = r_ls_rdata;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected
// grants, memory commands and read data; a negedge monitor checks them.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_req = 1'b0;
    logic [7:0]  f_addr = '0;
    logic        ls_req = 1'b0;
    logic        ls_rd = 1'b1;
    logic [7:0]  ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic [31:0] mem_rdata = '0;

    logic        f_gnt, f_rvalid, ls_gnt, ls_rvalid, err;
    logic        mem_en, mem_rd;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, f_rdata, ls_rdata;
    logic [15:0] conflict_cnt;

    logic        w2_f_gnt, w2_f_rvalid, w2_ls_gnt, w2_ls_rvalid, w2_err;
    logic        w2_mem_en, w2_mem_rd;
    logic [7:0]  w2_mem_addr;
    logic [31:0] w2_mem_wdata, w2_f_rdata, w2_ls_rdata;
    logic [1:0]  w2_cnt;

    mem_arbiter #(.AW(8), .DW(32), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rdata(f_rdata), .f_rvalid(f_rvalid),
        .ls_req(ls_req), .ls_rd(ls_rd), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
        .ls_rdata(ls_rdata), .err(err),
        .mem_en(mem_en), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .conflict_cnt(conflict_cnt)
    );

    mem_arbiter #(.AW(8), .DW(32), .CW(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(w2_f_gnt),
        .f_rdata(w2_f_rdata), .f_rvalid(w2_f_rvalid),
        .ls_req(ls_req), .ls_rd(ls_rd), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(w2_ls_gnt), .ls_rvalid(w2_ls_rvalid),
        .ls_rdata(w2_ls_rdata), .err(w2_err),
        .mem_en(w2_mem_en), .mem_rd(w2_mem_rd), .mem_addr(w2_mem_addr),
        .mem_wdata(w2_mem_wdata), .mem_rdata(mem_rdata),
        .conflict_cnt(w2_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = i;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_rd) mem_rdata <= mem[mem_addr];
            else        mem[mem_addr] <= mem_wdata;
        end
    end

    typedef struct { bit ls; bit err; int cyc; } gnt_t;
    typedef struct { bit rd; logic [7:0] addr; logic [31:0] wd; int cyc; } cmd_t;
    typedef struct { logic [31:0] d; int cyc; } rsp_t;

    gnt_t gq[$];
    cmd_t mq[$];
    rsp_t fq[$];
    rsp_t lq[$];

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk_eq(input string nm, input logic [63:0] act,
                          input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic exp_gnt(input bit ls, input bit e, input int c);
        gnt_t g;
        g.ls = ls; g.err = e; g.cyc = c;
        gq.push_back(g);
    endtask

    task automatic exp_cmd(input bit rd, input logic [7:0] a,
                           input logic [31:0] wd, input int c);
        cmd_t m;
        m.rd = rd; m.addr = a; m.wd = wd; m.cyc = c;
        mq.push_back(m);
    endtask

    task automatic exp_rsp(input bit ls, input logic [31:0] d, input int c);
        rsp_t r;
        r.d = d; r.cyc = c;
        if (ls) lq.push_back(r);
        else    fq.push_back(r);
    endtask

    always @(negedge clk) begin
        gnt_t g;
        cmd_t m;
        rsp_t r;
        if (f_gnt || ls_gnt || err) begin
            chk_eq("gnt_expected", gq.size() > 0, 1);
            if (gq.size() > 0) begin
                g = gq.pop_front();
                chk_eq("gnt_who", {f_gnt, ls_gnt}, {!g.ls, g.ls});
                chk_eq("gnt_err", err, g.err);
                if (g.cyc >= 0) chk_eq("gnt_cycle", cyc, g.cyc);
            end
        end
        if (mem_en) begin
            chk_eq("mem_expected", mq.size() > 0, 1);
            if (mq.size() > 0) begin
                m = mq.pop_front();
                chk_eq("mem_rd", mem_rd, m.rd);
                chk_eq("mem_addr", mem_addr, m.addr);
                if (!m.rd) chk_eq("mem_wdata", mem_wdata, m.wd);
                if (m.cyc >= 0) chk_eq("mem_cycle", cyc, m.cyc);
            end
        end
        if (f_rvalid) begin
            chk_eq("f_rvalid_expected", fq.size() > 0, 1);
            if (fq.size() > 0) begin
                r = fq.pop_front();
                chk_eq("f_rdata", f_rdata, r.d);
                if (r.cyc >= 0) chk_eq("f_rvalid_cycle", cyc, r.cyc);
            end
        end
        if (ls_rvalid) begin
            chk_eq("ls_rvalid_expected", lq.size() > 0, 1);
            if (lq.size() > 0) begin
                r = lq.pop_front();
                chk_eq("ls_rdata", ls_rdata, r.d);
                if (r.cyc >= 0) chk_eq("ls_rvalid_cycle", cyc, r.cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gnt(input bit any, input bit ls);
        int n = 0;
        bit got = 0;
        do begin
            @(negedge clk);
            n++;
            got = any ? (f_gnt || ls_gnt) : (ls ? ls_gnt : f_gnt);
        end while (!got && n < 40);
        chk_eq("gnt_seen", got, 1);
    endtask

    task automatic check_reset_vals();
        chk_eq("rst_pulses", {f_gnt, ls_gnt, f_rvalid, ls_rvalid, err, mem_en}, 6'b0);
        chk_eq("rst_mem_rd", mem_rd, 1);
        chk_eq("rst_mem_addr", mem_addr, 0);
        chk_eq("rst_mem_wdata", mem_wdata, 0);
        chk_eq("rst_f_rdata", f_rdata, 0);
        chk_eq("rst_ls_rdata", ls_rdata, 0);
        chk_eq("rst_cnt", conflict_cnt, 0);
        chk_eq("rst_cnt_cw2", w2_cnt, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        check_reset_vals();
        rst_n = 1'b1;
    endtask

    task automatic fetch_read5();
        int t0;
        @(negedge clk);
        t0 = cyc;
        exp_gnt(0, 0, t0 + 1);
        exp_cmd(1, 8'd5, 32'h0, t0 + 1);
        exp_rsp(0, 32'h5, t0 + 3);
        f_req = 1'b1; f_addr = 8'd5;
        wait_gnt(0, 0);
        f_req = 1'b0;
        idle(6);
    endtask

    initial begin
        int t0;
        do_reset();

        // single fetch read
        fetch_read5();

        // ls write then back-to-back ls read of the same word
        @(negedge clk);
        t0 = cyc;
        exp_gnt(1, 0, t0 + 1);
        exp_cmd(0, 8'd130, 32'hDEADBEEF, t0 + 1);
        exp_gnt(1, 0, t0 + 3);
        exp_cmd(1, 8'd130, 32'h0, t0 + 3);
        exp_rsp(1, 32'hDEADBEEF, t0 + 5);
        ls_req = 1'b1; ls_rd = 1'b0; ls_addr = 8'd130; ls_wdata = 32'hDEADBEEF;
        wait_gnt(0, 1);
        ls_rd = 1'b1;
        wait_gnt(0, 1);
        ls_req = 1'b0;
        idle(6);
        chk_eq("f_rdata_hold", f_rdata, 32'h5);

        // illegal ls address
        @(negedge clk);
        t0 = cyc;
        exp_gnt(1, 1, t0 + 1);
        ls_req = 1'b1; ls_rd = 1'b1; ls_addr = 8'd10;
        wait_gnt(0, 1);
        ls_req = 1'b0;
        idle(4);
        chk_eq("mem_addr_hold", mem_addr, 8'd130);
        chk_eq("ls_rdata_hold", ls_rdata, 32'hDEADBEEF);

        // illegal fetch address
        @(negedge clk);
        t0 = cyc;
        exp_gnt(0, 1, t0 + 1);
        f_req = 1'b1; f_addr = 8'd200;
        wait_gnt(0, 0);
        f_req = 1'b0;
        idle(4);

        // sustained conflict from reset: F, L, F, L
        do_reset();
        @(negedge clk);
        t0 = cyc;
        exp_gnt(0, 0, t0 + 1);  exp_cmd(1, 8'd7,   32'h0, t0 + 1);
        exp_gnt(1, 0, t0 + 5);  exp_cmd(1, 8'd200, 32'h0, t0 + 5);
        exp_gnt(0, 0, t0 + 9);  exp_cmd(1, 8'd7,   32'h0, t0 + 9);
        exp_gnt(1, 0, t0 + 13); exp_cmd(1, 8'd200, 32'h0, t0 + 13);
        exp_rsp(0, 32'h7,  t0 + 3);
        exp_rsp(1, 32'hC8, t0 + 7);
        exp_rsp(0, 32'h7,  t0 + 11);
        exp_rsp(1, 32'hC8, t0 + 15);
        f_req = 1'b1; f_addr = 8'd7;
        ls_req = 1'b1; ls_rd = 1'b1; ls_addr = 8'd200;
        for (int i = 0; i < 4; i++) wait_gnt(1, 0);
        f_req = 1'b0; ls_req = 1'b0;
        idle(6);
        chk_eq("conflict_cnt", conflict_cnt, 16'd4);
        chk_eq("conflict_cnt_sat", w2_cnt, 2'd3);

        // reset while a fetch read sits in WAIT
        @(negedge clk);
        t0 = cyc;
        exp_gnt(0, 0, t0 + 1);
        exp_cmd(1, 8'd5, 32'h0, t0 + 1);
        f_req = 1'b1; f_addr = 8'd5;
        wait_gnt(0, 0);
        f_req = 1'b0;
        @(negedge clk);
        do_reset();
        idle(5);
        fetch_read5();

        idle(4);
        chk_eq("gnt_left", gq.size(), 0);
        chk_eq("mem_left", mq.size(), 0);
        chk_eq("f_rsp_left", fq.size(), 0);
        chk_eq("ls_rsp_left", lq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
